de0_operand_entry: RTL and testbench
====================================

Name: de0_operand_entry

Overview:
- Producer side of the DE0 4-bit two's-complement comparator datapath: lets the user dial in operands X and Y with three pushbuttons and hands both to the comparator.
- Buttons are synchronised and debounced, and each press becomes a one-cycle pulse.
- A 3-state FSM edits X, then Y, then holds both stable with a valid flag.
- The cur/sel_y outputs feed the existing 7-segment encoders so the value being edited is always displayed.

Parameters:
- W, 4, operand width in bits.
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples required to accept a new button level (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk.
- btn_dec  in  1  raw decrement button, active-high, asynchronous.
- btn_enter  in  1  raw enter button, active-high, asynchronous.
- negselect  in  1  1 = signed two's-complement range, 0 = unsigned range.
- cur  out  W  value currently being edited.
- sel_y  out  1  1 while editing Y, 0 otherwise.
- X  out  W  committed operand X.
- Y  out  W  committed operand Y.
- valid  out  1  X and Y both committed and stable.
- done  out  1  one-cycle pulse when Y is committed.

Interface decision: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, immediate, including mid-edit or mid-debounce):
  - X=0, Y=0, cur=0, sel_y=0, valid=0, done=0, state=EDIT_X.
  - Synchroniser flops, debounce counters and debounced levels all cleared to 0.
- Button path, per button:
  - 2-flop synchroniser.
  - Counter resets whenever the synchronised value equals the debounced level. Otherwise it increments; at DEBOUNCE_CYCLES-1 it loads the debounced level and clears.
  - Press pulse = debounced 0->1 transition, exactly one cycle wide. Release produces nothing.
  - Latency: pulse asserts DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge.
  - A glitch shorter than DEBOUNCE_CYCLES samples produces no pulse.
  - A button held through reset release produces exactly one press after debounce.
- FSM states are EDIT_X, EDIT_Y and SHOW. Register updates land on the clock edge after the pulse.
  - EDIT_X:
    - inc/dec adjust cur.
    - enter: X<=cur, cur<=Y, sel_y<=1, go to EDIT_Y.
  - EDIT_Y:
    - inc/dec adjust cur.
    - enter: Y<=cur, valid<=1, done pulses for 1 cycle, sel_y<=0, go to SHOW.
  - SHOW:
    - inc/dec ignored; X, Y and cur are held.
    - enter: valid<=0, cur<=X, go to EDIT_X.
- Arithmetic on cur is saturating, never wrap-around:
  - negselect=1: range -8..+7 (0x8..0x7). inc at 0x7 keeps 0x7; dec at 0x8 keeps 0x8.
  - negselect=0: range 0..15. inc at 0xF keeps 0xF; dec at 0x0 keeps 0x0.
  - Changing negselect mid-edit leaves the cur bits untouched; the new range applies from the next step.
- Simultaneous pulses in the same cycle:
  - enter has priority, and any inc/dec is dropped.
  - inc together with dec gives no change.
- X and Y change only on their commit edges. valid stays high throughout SHOW.

Decomposition:
- Shared package de0_entry_pkg holds:
  - W default.
  - State encoding constants ST_EDIT_X=2'd0, ST_EDIT_Y=2'd1, ST_SHOW=2'd2.
  - Range constants SMAX=4'h7, SMIN=4'h8, UMAX=4'hF, UMIN=4'h0.
- One sub-module, btn_debounce (synchroniser, counter, debounced level, press pulse), instantiated three times.
- Saturation and the FSM stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset mid-debounce: assert rst while btn_inc bounces -> all outputs 0 immediately; no pulse appears after release of rst.
- Clean press of btn_inc -> cur goes 0->1 exactly 8 cycles after the raw rise. A 2-cycle glitch -> cur unchanged.
- Signed saturation: negselect=1, 10 inc presses -> cur=0x7. Then 20 dec presses -> cur=0x8. Switch to negselect=0 and press inc 8 times -> cur=0xF.
- Full entry sequence:
  - Enter X=0x3 -> X=3, sel_y=1, cur=0.
  - Dial Y=0xE and press enter -> Y=0xE, valid=1, done high for 1 cycle.
  - Press inc in SHOW -> cur, X and Y unchanged.
- Simultaneous presses:
  - Raw btn_inc and btn_enter rising together in EDIT_X with cur=5 -> X=5, cur stays unincremented.
  - btn_inc and btn_dec rising together -> cur unchanged.
- Re-edit: press enter in SHOW -> valid=0, cur=X, sel_y=0. Reset during EDIT_Y -> state EDIT_X, X=0, Y=0.

Source files
------------

// File: rtl/de0_entry_pkg.sv
// Shared definitions for the DE0 operand-entry block: operand width, FSM
// state encoding and the 4-bit saturation limits.
package de0_entry_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        ST_EDIT_X = 2'd0,
        ST_EDIT_Y = 2'd1,
        ST_SHOW   = 2'd2
    } state_t;

    localparam logic [W_DEF-1:0] SMAX = 4'h7;
    localparam logic [W_DEF-1:0] SMIN = 4'h8;
    localparam logic [W_DEF-1:0] UMAX = 4'hF;
    localparam logic [W_DEF-1:0] UMIN = 4'h0;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton path: 2-flop synchroniser, stability counter, debounced
// level and a registered one-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          meta;
    logic          sync;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // NOTE: every register here is state, so all use <=; blocking writes would
    // let sync see this cycle's meta and collapse the two-flop synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            meta    <= raw;
            sync    <= meta;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/de0_operand_entry.sv
// Operand entry for the DE0 comparator: three debounced buttons drive an
// EDIT_X -> EDIT_Y -> SHOW editor with saturating inc/dec of the shown value.
module de0_operand_entry
    import de0_entry_pkg::*;
#(
    parameter int W               = W_DEF,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_inc,
    input  logic         btn_dec,
    input  logic         btn_enter,
    input  logic         negselect,
    output logic [W-1:0] cur,
    output logic         sel_y,
    output logic [W-1:0] X,
    output logic [W-1:0] Y,
    output logic         valid,
    output logic         done
);

    localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] U_MAX = '1;
    localparam logic [W-1:0] U_MIN = '0;

    logic         inc_p;
    logic         dec_p;
    logic         enter_p;
    logic [W-1:0] hi_lim;
    logic [W-1:0] lo_lim;
    logic [W-1:0] stepped;
    state_t       state;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .raw(btn_inc), .press(inc_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .rst(rst), .raw(btn_dec), .press(dec_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst(rst), .raw(btn_enter), .press(enter_p)
    );

    // NOTE: stepped gets its default first so no path through this block
    // leaves it unassigned and infers a latch.
    always_comb begin
        hi_lim  = negselect ? S_MAX : U_MAX;
        lo_lim  = negselect ? S_MIN : U_MIN;
        stepped = cur;
        if (inc_p && !dec_p && cur != hi_lim) begin
            stepped = cur + 1'b1;
        end else if (dec_p && !inc_p && cur != lo_lim) begin
            stepped = cur - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EDIT_X;
            cur   <= '0;
            sel_y <= 1'b0;
            X     <= '0;
            Y     <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            // enter wins over inc/dec arriving in the same cycle
            case (state)
                ST_EDIT_X: begin
                    if (enter_p) begin
                        X     <= cur;
                        cur   <= Y;
                        sel_y <= 1'b1;
                        state <= ST_EDIT_Y;
                    end else begin
                        cur <= stepped;
                    end
                end
                ST_EDIT_Y: begin
                    if (enter_p) begin
                        Y     <= cur;
                        valid <= 1'b1;
                        done  <= 1'b1;
                        sel_y <= 1'b0;
                        state <= ST_SHOW;
                    end else begin
                        cur <= stepped;
                    end
                end
                ST_SHOW: begin
                    if (enter_p) begin
                        valid <= 1'b0;
                        cur   <= X;
                        state <= ST_EDIT_X;
                    end
                end
                default: state <= ST_EDIT_X;
            endcase
        end
    end

endmodule

// File: tb/tb_de0_operand_entry.sv
// Directed bench for de0_operand_entry with a short debounce window: a table
// of button presses with expected outputs plus hand-written timing sequences.
module tb_de0_operand_entry;
    import de0_entry_pkg::*;

    localparam int DEB = 4;
    localparam int NR  = 15;

    typedef struct {
        logic [2:0] btn;   // {inc, dec, enter}
        logic       ns;
        int         reps;
        logic [3:0] cur;
        logic       sel;
        logic [3:0] x;
        logic [3:0] y;
        logic       valid;
    } row_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_enter = 1'b0;
    logic       negselect = 1'b1;
    logic [3:0] cur;
    logic       sel_y;
    logic [3:0] X;
    logic [3:0] Y;
    logic       valid;
    logic       done;

    int   n_checks = 0;
    int   n_pass   = 0;
    row_t rows [NR];

    de0_operand_entry #(.W(4), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_enter(btn_enter), .negselect(negselect), .cur(cur),
        .sel_y(sel_y), .X(X), .Y(Y), .valid(valid), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [3:0] c, input logic s,
                             input logic [3:0] x, input logic [3:0] y, input logic v);
        check({tag, " cur"}, 32'(cur), 32'(c));
        check({tag, " sel_y"}, 32'(sel_y), 32'(s));
        check({tag, " X"}, 32'(X), 32'(x));
        check({tag, " Y"}, 32'(Y), 32'(y));
        check({tag, " valid"}, 32'(valid), 32'(v));
    endtask

    // Raise the selected raw buttons together, hold past debounce, release, settle.
    task automatic press(input logic [2:0] b);
        @(posedge clk); #1;
        btn_inc   = b[2];
        btn_dec   = b[1];
        btn_enter = b[0];
        repeat (10) @(posedge clk);
        #1;
        btn_inc   = 1'b0;
        btn_dec   = 1'b0;
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            negselect = rows[r].ns;
            for (int k = 0; k < rows[r].reps; k++) press(rows[r].btn);
            @(negedge clk);
            check_all($sformatf("row%0d", r), rows[r].cur, rows[r].sel,
                      rows[r].x, rows[r].y, rows[r].valid);
        end
    endtask

    function automatic row_t mk(input logic [2:0] b, input logic ns, input int reps,
                                input logic [3:0] c, input logic s, input logic [3:0] x,
                                input logic [3:0] y, input logic v);
        row_t t;
        t.btn = b; t.ns = ns; t.reps = reps; t.cur = c;
        t.sel = s; t.x = x; t.y = y; t.valid = v;
        return t;
    endfunction

    initial begin
        int hi_cnt;

        rows[0]  = mk(3'b100, 1'b1, 10, SMAX,  1'b0, 4'h0, 4'h0, 1'b0);
        rows[1]  = mk(3'b010, 1'b1, 20, SMIN,  1'b0, 4'h0, 4'h0, 1'b0);
        rows[2]  = mk(3'b100, 1'b0, 8,  UMAX,  1'b0, 4'h0, 4'h0, 1'b0);
        rows[3]  = mk(3'b010, 1'b0, 12, 4'h3,  1'b0, 4'h0, 4'h0, 1'b0);
        rows[4]  = mk(3'b001, 1'b0, 1,  4'h0,  1'b1, 4'h3, 4'h0, 1'b0);
        rows[5]  = mk(3'b010, 1'b0, 1,  UMIN,  1'b1, 4'h3, 4'h0, 1'b0);
        rows[6]  = mk(3'b010, 1'b1, 2,  4'hE,  1'b1, 4'h3, 4'h0, 1'b0);
        rows[7]  = mk(3'b100, 1'b0, 1,  4'hE,  1'b0, 4'h3, 4'hE, 1'b1);
        rows[8]  = mk(3'b010, 1'b0, 1,  4'hE,  1'b0, 4'h3, 4'hE, 1'b1);
        rows[9]  = mk(3'b001, 1'b0, 1,  4'h3,  1'b0, 4'h3, 4'hE, 1'b0);
        rows[10] = mk(3'b100, 1'b0, 2,  4'h5,  1'b0, 4'h3, 4'hE, 1'b0);
        rows[11] = mk(3'b101, 1'b0, 1,  4'hE,  1'b1, 4'h5, 4'hE, 1'b0);
        rows[12] = mk(3'b110, 1'b0, 1,  4'hE,  1'b1, 4'h5, 4'hE, 1'b0);
        rows[13] = mk(3'b100, 1'b1, 1,  4'hF,  1'b1, 4'h5, 4'hE, 1'b0);
        rows[14] = mk(3'b001, 1'b0, 1,  4'h0,  1'b1, 4'h1, 4'h0, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        check("reset done", 32'(done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset mid-debounce: counter partly advanced, then cleared; no pulse later
        @(posedge clk); #1 btn_inc = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst mid-debounce cur", 32'(cur), 32'd0);
        btn_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("no pulse after rst cur", 32'(cur), 32'd0);

        // Latency: cur changes exactly 8 cycles after the raw rise
        @(posedge clk); #1 btn_inc = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("latency edge7 cur", 32'(cur), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency edge8 cur", 32'(cur), 32'd1);
        btn_inc = 1'b0;
        repeat (12) @(posedge clk);

        // 2-cycle glitch is filtered
        @(posedge clk); #1 btn_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1 btn_inc = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("glitch cur", 32'(cur), 32'd1);

        run_rows(0, 6);

        // Commit Y: done must be high for exactly one cycle
        @(posedge clk); #1 btn_enter = 1'b1;
        hi_cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) hi_cnt++;
        end
        btn_enter = 1'b0;
        check("done width", 32'(hi_cnt), 32'd1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_all("commitY", 4'hE, 1'b0, 4'h3, 4'hE, 1'b1);

        run_rows(7, 13);

        // Async reset during EDIT_Y with inc held through reset release
        @(posedge clk); #3 rst = 1'b1;
        btn_inc = 1'b1;
        #1 check_all("rst editY", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 btn_inc = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("held-through-reset cur", 32'(cur), 32'd1);
        check("held-through-reset sel_y", 32'(sel_y), 32'd0);

        run_rows(14, 14);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
